// File: rtl/mem_stage_if.sv
// M-to-W pipeline bundle for the data-memory stage: M-stage inputs and
// registered W-stage outputs. The stage itself is the slave.
interface mem_stage_if;
    logic [31:0] instr_M;
    logic [31:0] PC_M;
    logic [31:0] PC8_M;
    logic [31:0] C_M;
    logic [31:0] RD2_M;
    logic [4:0]  A3_M;
    logic        fwd_rt_M;
    logic [31:0] WD_W;

    logic [31:0] instr_W;
    logic [31:0] PC_W;
    logic [31:0] PC8_W;
    logic [31:0] C_W;
    logic [31:0] DR_W;
    logic [4:0]  A3_W;

    modport master (
        output instr_M, PC_M, PC8_M, C_M, RD2_M, A3_M, fwd_rt_M, WD_W,
        input  instr_W, PC_W, PC8_W, C_W, DR_W, A3_W
    );

    modport slave (
        input  instr_M, PC_M, PC8_M, C_M, RD2_M, A3_M, fwd_rt_M, WD_W,
        output instr_W, PC_W, PC8_W, C_W, DR_W, A3_W
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: 3072-word data memory with byte/half/word loads and
// stores, store-data forwarding from W, and the M/W pipeline register.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  bus
);
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam int         WORDS  = 3072;

    logic [31:0] mem [0:WORDS-1];

    logic [5:0]  opcode;
    logic [11:0] widx;
    logic        in_range;
    logic [31:0] sd;
    logic [31:0] rword;
    logic [15:0] rhalf;
    logic [7:0]  rbyte;
    logic [31:0] load_data;
    logic [31:0] wword;
    logic        do_store;

    // Addresses at or above 0x3000 never touch the array, so the 12-bit
    // index (which can reach 4095) is only used when in_range holds.
    always_comb begin
        opcode   = bus.instr_M[31:26];
        widx     = bus.C_M[13:2];
        in_range = bus.C_M < 32'h0000_3000;
        sd       = bus.fwd_rt_M ? bus.WD_W : bus.RD2_M;
        rword    = in_range ? mem[widx] : 32'h0;
        rhalf    = bus.C_M[1] ? rword[31:16] : rword[15:0];
        case (bus.C_M[1:0])
            2'd0:    rbyte = rword[7:0];
            2'd1:    rbyte = rword[15:8];
            2'd2:    rbyte = rword[23:16];
            default: rbyte = rword[31:24];
        endcase

        load_data = 32'h0;
        case (opcode)
            OP_LW:   load_data = rword;
            OP_LH:   load_data = {{16{rhalf[15]}}, rhalf};
            OP_LHU:  load_data = {16'h0, rhalf};
            OP_LB:   load_data = {{24{rbyte[7]}}, rbyte};
            OP_LBU:  load_data = {24'h0, rbyte};
            default: load_data = 32'h0;
        endcase

        // Partial stores merge into the current word so untouched lanes survive.
        do_store = 1'b0;
        wword    = rword;
        case (opcode)
            OP_SW: begin
                do_store = 1'b1;
                wword    = sd;
            end
            OP_SH: begin
                do_store = 1'b1;
                if (bus.C_M[1]) wword[31:16] = sd[15:0];
                else            wword[15:0]  = sd[15:0];
            end
            OP_SB: begin
                do_store = 1'b1;
                case (bus.C_M[1:0])
                    2'd0:    wword[7:0]   = sd[7:0];
                    2'd1:    wword[15:8]  = sd[7:0];
                    2'd2:    wword[23:16] = sd[7:0];
                    default: wword[31:24] = sd[7:0];
                endcase
            end
            default: do_store = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= 32'h0;
        end else if (do_store && in_range) begin
            mem[widx] <= wword;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.instr_W <= 32'h0;
            bus.PC_W    <= 32'h0;
            bus.PC8_W   <= 32'h0;
            bus.C_W     <= 32'h0;
            bus.DR_W    <= 32'h0;
            bus.A3_W    <= 5'h0;
        end else begin
            bus.instr_W <= bus.instr_M;
            bus.PC_W    <= bus.PC_M;
            bus.PC8_W   <= bus.PC8_M;
            bus.C_W     <= bus.C_M;
            bus.DR_W    <= load_data;
            bus.A3_W    <= bus.A3_M;
        end
    end
endmodule
